// File: rtl/logic_arbiter.sv
// Two-requester round-robin arbiter in front of a 4-function bitwise logic unit.
// The result is held in a one-entry response slot that honours consumer backpressure.
module logic_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req0_valid,
  output logic             o_req0_ready,
  input  logic [1:0]       i_req0_op,
  input  logic [WIDTH-1:0] i_req0_a,
  input  logic [WIDTH-1:0] i_req0_b,
  input  logic             i_req1_valid,
  output logic             o_req1_ready,
  input  logic [1:0]       i_req1_op,
  input  logic [WIDTH-1:0] i_req1_a,
  input  logic [WIDTH-1:0] i_req1_b,
  output logic             o_rsp_valid,
  input  logic             i_rsp_ready,
  output logic             o_rsp_id,
  output logic [1:0]       o_rsp_op,
  output logic [WIDTH-1:0] o_rsp_data,
  output logic             o_rsp_zero
);

  localparam logic [1:0] OP_XOR = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;

  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [1:0]       r_rsp_op;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_prio;

  logic             w_slot_free;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_xfer0;
  logic             w_xfer1;
  logic             w_xfer;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [WIDTH-1:0] w_result;

  // A stalled slot blocks every grant; prio only matters under contention.
  assign w_slot_free = !r_rsp_valid || i_rsp_ready;
  assign w_grant0    = i_req0_valid && (!i_req1_valid || !r_prio);
  assign w_grant1    = i_req1_valid && (!i_req0_valid || r_prio);

  assign o_req0_ready = w_grant0 && w_slot_free && i_rst_n;
  assign o_req1_ready = w_grant1 && w_slot_free && i_rst_n;

  assign w_xfer0 = i_req0_valid && o_req0_ready;
  assign w_xfer1 = i_req1_valid && o_req1_ready;
  assign w_xfer  = w_xfer0 || w_xfer1;

  assign w_op = w_xfer1 ? i_req1_op : i_req0_op;
  assign w_a  = w_xfer1 ? i_req1_a  : i_req0_a;
  assign w_b  = w_xfer1 ? i_req1_b  : i_req0_b;

  always_comb begin
    w_result = '0;
    case (w_op)
      OP_XOR:  w_result = w_a ^ w_b;
      OP_AND:  w_result = w_a & w_b;
      OP_OR:   w_result = w_a | w_b;
      default: w_result = ~(w_a | w_b);
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_op    <= 2'b00;
      r_rsp_data  <= '0;
      r_rsp_zero  <= 1'b0;
      r_prio      <= 1'b0;
    end else if (w_xfer) begin
      r_rsp_valid <= 1'b1;
      r_rsp_id    <= w_xfer1;
      r_rsp_op    <= w_op;
      r_rsp_data  <= w_result;
      r_rsp_zero  <= (w_result == '0);
      r_prio      <= !w_xfer1;
    end else if (i_rsp_ready) begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_op    = r_rsp_op;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_zero  = r_rsp_zero;

endmodule

// File: tb/tb_logic_arbiter.sv
// Bench for logic_arbiter: constant vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_logic_arbiter;

  logic       clk;
  logic       rst_n;
  logic       v0, v1, rr;
  logic [1:0] op0, op1;
  logic [3:0] a0, b0, a1, b1;
  logic       r0, r1;
  logic       rsp_valid, rsp_id, rsp_zero;
  logic [1:0] rsp_op;
  logic [3:0] rsp_data;

  int errors = 0;
  int checks = 0;

  // reference model state
  bit       m_valid;
  bit       m_id;
  bit [1:0] m_op;
  bit [3:0] m_data;
  bit       m_zero;
  int       m_prio;
  logic     s_r0, s_r1;

  logic_arbiter #(.WIDTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_op(op0), .i_req0_a(a0), .i_req0_b(b0),
    .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_op(op1), .i_req1_a(a1), .i_req1_b(b1),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rr), .o_rsp_id(rsp_id), .o_rsp_op(rsp_op),
    .o_rsp_data(rsp_data), .o_rsp_zero(rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Each bit of the result is a truth-table lookup on {a_bit, b_bit}.
  function automatic bit [3:0] ref_fn(input bit [1:0] op, input bit [3:0] a, input bit [3:0] b);
    bit [3:0] tt [4];
    bit [3:0] t;
    bit [3:0] r;
    tt[0] = 4'b0110; tt[1] = 4'b1000; tt[2] = 4'b1110; tt[3] = 4'b0001;
    t = tt[op];
    for (int i = 0; i < 4; i++) r[i] = t[{a[i], b[i]}];
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_id = 0; m_op = 0; m_data = 0; m_zero = 0; m_prio = 0;
  endtask

  // One clock cycle: drive at negedge, check readies, step the edge, check the slot.
  task automatic cyc(input bit iv0, input bit [1:0] iop0, input bit [3:0] ia0, input bit [3:0] ib0,
                     input bit iv1, input bit [1:0] iop1, input bit [3:0] ia1, input bit [3:0] ib1,
                     input bit irr);
    int win;
    v0 = iv0; op0 = iop0; a0 = ia0; b0 = ib0;
    v1 = iv1; op1 = iop1; a1 = ia1; b1 = ib1;
    rr = irr;
    #1;
    if (iv0 && iv1)  win = m_prio;
    else if (iv0)    win = 0;
    else if (iv1)    win = 1;
    else             win = -1;
    if (m_valid && !irr) win = -1;
    s_r0 = r0; s_r1 = r1;
    chk("req0_ready", {31'd0, r0}, {31'd0, win == 0});
    chk("req1_ready", {31'd0, r1}, {31'd0, win == 1});
    @(posedge clk);
    if (win >= 0) begin
      m_valid = 1;
      m_id    = (win == 1);
      m_op    = (win == 1) ? iop1 : iop0;
      m_data  = (win == 1) ? ref_fn(iop1, ia1, ib1) : ref_fn(iop0, ia0, ib0);
      m_zero  = (m_data == 0);
      m_prio  = 1 - win;
    end else if (irr) begin
      m_valid = 0;
    end
    @(negedge clk);
    chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
    chk("rsp_id",    {31'd0, rsp_id},    {31'd0, m_id});
    chk("rsp_op",    {30'd0, rsp_op},    {30'd0, m_op});
    chk("rsp_data",  {28'd0, rsp_data},  {28'd0, m_data});
    chk("rsp_zero",  {31'd0, rsp_zero},  {31'd0, m_zero});
  endtask

  typedef struct {
    bit       rid;
    bit [1:0] op;
    bit [3:0] a;
    bit [3:0] b;
    bit [3:0] exp_data;
    bit       exp_zero;
  } vec_t;

  vec_t vt [6];
  logic [3:0] hold_data;

  initial begin
    vt[0] = '{0, 2'b00, 4'b1100, 4'b1010, 4'b0110, 0};
    vt[1] = '{0, 2'b01, 4'b1100, 4'b1010, 4'b1000, 0};
    vt[2] = '{0, 2'b10, 4'b1100, 4'b1010, 4'b1110, 0};
    vt[3] = '{0, 2'b11, 4'b1100, 4'b1010, 4'b0001, 0};
    vt[4] = '{1, 2'b11, 4'hF,    4'h0,    4'h0,    1};
    vt[5] = '{1, 2'b01, 4'h5,    4'hA,    4'h0,    1};

    v0 = 0; v1 = 0; rr = 0; op0 = 0; op1 = 0; a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    rst_n = 0;
    model_reset();
    #12;
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_data",  {28'd0, rsp_data},  32'd0);
    rst_n = 1;
    @(negedge clk);

    // constant vectors, back-to-back with rsp_ready high
    for (int i = 0; i < 6; i++) begin
      cyc(!vt[i].rid, vt[i].op, vt[i].a, vt[i].b, vt[i].rid, vt[i].op, vt[i].a, vt[i].b, 1);
      chk("vec data", {28'd0, rsp_data}, {28'd0, vt[i].exp_data});
      chk("vec zero", {31'd0, rsp_zero}, {31'd0, vt[i].exp_zero});
      chk("vec id",   {31'd0, rsp_id},   {31'd0, vt[i].rid});
      chk("vec op",   {30'd0, rsp_op},   {30'd0, vt[i].op});
      chk("vec valid", {31'd0, rsp_valid}, 32'd1);
    end

    // contention alternates 0,1,0,1,0,1 (prio is 0 after requester 1 won last)
    for (int i = 0; i < 6; i++) begin
      cyc(1, 2'b00, 4'h3, 4'h5, 1, 2'b10, 4'h8, 4'h1, 1);
      chk("rr id", {31'd0, rsp_id}, i % 2);
    end
    // only requester 1 for 3 cycles, then contention must go to 0
    for (int i = 0; i < 3; i++) begin
      cyc(0, 2'b00, 4'h0, 4'h0, 1, 2'b00, 4'h6, 4'h3, 1);
      chk("solo1 id", {31'd0, rsp_id}, 32'd1);
    end
    cyc(1, 2'b01, 4'hF, 4'h3, 1, 2'b10, 4'h4, 4'h8, 1);
    chk("prio after solo1", {31'd0, s_r0}, 32'd1);

    // backpressure: slot holds 4'h3 from requester 0, five stalled cycles
    for (int i = 0; i < 5; i++) begin
      cyc(1, 2'b00, 4'h1, 4'h2, 1, 2'b10, 4'h4, 4'h8, 0);
      chk("bp data hold", {28'd0, rsp_data}, 32'h3);
    end
    cyc(1, 2'b00, 4'h1, 4'h2, 1, 2'b10, 4'h4, 4'h8, 1);
    chk("bp resume ready1", {31'd0, s_r1}, 32'd1);
    chk("bp resume data", {28'd0, rsp_data}, 32'hC);
    chk("bp resume valid", {31'd0, rsp_valid}, 32'd1);

    // idle drain: valid falls, data holds, prio (=0) unchanged
    cyc(0, 2'b00, 4'h0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 1);
    chk("idle valid", {31'd0, rsp_valid}, 32'd0);
    chk("idle data",  {28'd0, rsp_data},  32'hC);
    cyc(0, 2'b00, 4'h0, 4'h0, 0, 2'b00, 4'h0, 4'h0, 1);
    cyc(1, 2'b10, 4'h1, 4'h2, 1, 2'b10, 4'h4, 4'h8, 1);
    chk("idle prio", {31'd0, s_r0}, 32'd1);

    // asynchronous reset mid-cycle with a full slot
    cyc(0, 2'b00, 4'h0, 4'h0, 1, 2'b10, 4'h9, 4'h0, 0);
    hold_data = rsp_data;
    chk("pre-reset full", {31'd0, rsp_valid}, 32'd1);
    v0 = 1; v1 = 1; rr = 1;
    #2 rst_n = 0;
    #1;
    chk("async rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async rsp_data",  {28'd0, rsp_data},  32'd0);
    chk("async rsp_id",    {31'd0, rsp_id},    32'd0);
    chk("async ready0",    {31'd0, r0},        32'd0);
    chk("async ready1",    {31'd0, r1},        32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cyc(1, 2'b11, 4'h0, 4'h0, 1, 2'b00, 4'h1, 4'h1, 1);
    chk("post-reset grant0", {31'd0, s_r0}, 32'd1);
    chk("post-reset zero",   {31'd0, rsp_zero}, 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 1), 2'($urandom), 4'($urandom), 4'($urandom),
          $urandom_range(0, 1), 2'($urandom), 4'($urandom), 4'($urandom),
          $urandom_range(0, 3) != 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/logic_arbiter.md
# logic_arbiter

Two-requester round-robin arbiter and sequencer for the 4-bit logic unit (XOR/AND/OR/NOR). It accepts operation requests from two independent sources over valid/ready handshakes and grants the shared logic unit to one source per cycle. It computes the selected function and holds the result in a one-entry registered response slot with backpressure. It sits between the ALU's operand sources and its result path.

## Interface
- WIDTH, 4, operand and result width in bits.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous reset, active-low.
- req0_valid  in  1  requester 0 has a request.
- req0_ready  out  1  requester 0 request accepted this cycle when high with req0_valid.
- req0_op  in  2  operation select: 00 XOR, 01 AND, 10 OR, 11 NOR.
- req0_a, req0_b  in  WIDTH  operands.
- req1_valid, req1_ready, req1_op, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  response slot full.
- rsp_ready  in  1  consumer takes the response when high with rsp_valid.
- rsp_id  out  1  index of the requester that issued the response.
- rsp_op  out  2  op of the response.
- rsp_data  out  WIDTH  result.
- rsp_zero  out  1  high when rsp_data == 0.

## Operation
- Function per op: XOR = A^B, AND = A&B, OR = A|B, NOR = ~(A|B). All are bitwise across WIDTH bits, with no carry.
- Slot free condition: slot_free = !rsp_valid || rsp_ready.
- Grant selection (combinational):
  - If exactly one req valid, grant it.
  - If both valid, grant requester == prio.
  - If none valid, no grant.
- reqN_ready = grantN && slot_free && rst_n. At most one ready is high per cycle.
- reqN_ready may depend combinationally on rsp_ready and on reqN_valid. Requesters must not make valid depend on ready.
- Transfer on a clock edge with reqN_valid && reqN_ready:
  - The slot loads rsp_data = f(op, a, b), rsp_op = op, rsp_id = N, and rsp_zero.
  - rsp_valid is set to 1.
  - prio is set to ~N.
- Consume with rsp_valid && rsp_ready and no new transfer: rsp_valid is set to 0. The data fields hold their last values.
- Simultaneous consume and transfer: the slot is overwritten with the new result, and rsp_valid stays 1.
- When rsp_valid && !rsp_ready, the slot fields and rsp_valid hold, and prio holds.
- Requester inputs are sampled only on the accepting edge. Changes while not ready are ignored.
- prio changes only on an accepted transfer. It never changes on idle cycles or on a single-requester grant that is stalled.

## Timing
- Reset (rst_n low, asynchronous, no clock needed) forces:
  - rsp_valid 0, rsp_data 0, rsp_id 0, rsp_op 00, rsp_zero 0, and prio 0.
  - req0_ready and req1_ready 0 while rst_n is low.
- Reset mid-operation drops a pending response. The first grant after reset favours requester 0.
- Latency: a request accepted at edge k appears on the response outputs from just after edge k. It is visible in cycle k+1.
- Throughput: one transfer per cycle while rsp_ready is held high.
- Contention: with both requesters valid continuously and rsp_ready high, grants alternate 0,1,0,1.
- Backpressure: rsp_ready low with rsp_valid high blocks all grants. Transfers resume in the same cycle that rsp_ready rises.

## Test plan
- Reset: drive rst_n low mid-cycle with rsp_valid=1 -> outputs clear immediately with no clock edge: rsp_valid=0, rsp_data=0, both readies 0. After release, the first contended grant goes to 0.
- Op coverage via requester 0, A=4'b1100, B=4'b1010, ops 00..11 back-to-back with rsp_ready=1 -> rsp_data 0110, 1000, 1110, 0001 on consecutive cycles. rsp_id=0 and rsp_zero=0 for all four.
- Zero flag: requester 1 NOR, A=4'hF, B=4'h0 -> rsp_data=4'h0, rsp_zero=1, rsp_id=1, rsp_op=11.
- Round-robin: both valid for 6 cycles with rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1. Repeat with only req1 valid for 3 cycles -> req1 granted every cycle, then prio=0.
- Backpressure: rsp_valid=1, rsp_ready=0 for 5 cycles, both reqs valid -> readies 0 and response fields stable throughout. When rsp_ready=1, one request is accepted the same cycle and its result appears the next cycle with rsp_valid still 1.
- Single idle: no reqs valid, rsp_ready=1 -> rsp_valid falls after one edge. The data fields and prio are unchanged.
